// File: rtl/lu_pkg.sv
// Shared constants and types for the LU solver matrix loader.
package lu_pkg;

    localparam int WIDTH       = 16;
    localparam int FBITS       = 4;
    localparam int NUM_ENTRIES = 12;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SOLVE,
        ST_OUT,
        ST_DRAIN
    } state_t;

    // Load order of the serial entry stream
    localparam logic [3:0] IDX_A00 = 4'd0;
    localparam logic [3:0] IDX_A01 = 4'd1;
    localparam logic [3:0] IDX_A02 = 4'd2;
    localparam logic [3:0] IDX_A10 = 4'd3;
    localparam logic [3:0] IDX_A11 = 4'd4;
    localparam logic [3:0] IDX_A12 = 4'd5;
    localparam logic [3:0] IDX_A20 = 4'd6;
    localparam logic [3:0] IDX_A21 = 4'd7;
    localparam logic [3:0] IDX_A22 = 4'd8;
    localparam logic [3:0] IDX_C0  = 4'd9;
    localparam logic [3:0] IDX_C1  = 4'd10;
    localparam logic [3:0] IDX_C2  = 4'd11;

endpackage

// File: rtl/lu_matrix_loader.sv
// Serial loader for a 3x3 LU solve: collects A and C, runs the solver, streams X back.
// Optional zero-pivot precheck on A00 enabled by defining LU_LOADER_PIVOT_CHECK_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_LOAD  | accept the 12 entries A00..A22, C0..C2 in order
// ST_SOLVE | solver_en high, matrix held, wait for solver_done
// ST_OUT   | stream X0, X1, X2 with out_idx 0..2 under out_ready
// ST_DRAIN | wait for solver_done to drop before the next load
module lu_matrix_loader
    import lu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] A00,
    output logic [WIDTH-1:0] A01,
    output logic [WIDTH-1:0] A02,
    output logic [WIDTH-1:0] A10,
    output logic [WIDTH-1:0] A11,
    output logic [WIDTH-1:0] A12,
    output logic [WIDTH-1:0] A20,
    output logic [WIDTH-1:0] A21,
    output logic [WIDTH-1:0] A22,
    output logic [WIDTH-1:0] C0,
    output logic [WIDTH-1:0] C1,
    output logic [WIDTH-1:0] C2,
    output logic             solver_en,
    input  logic             solver_done,
    input  logic             solver_error_ovf,
    input  logic             solver_error_dbz,
    input  logic             solver_error_fsm,
    input  logic [WIDTH-1:0] X0,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] X2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_idx,
    input  logic             out_ready,
    output logic [3:0]       status
);

    state_t           state;
    logic [3:0]       k;
    logic [WIDTH-1:0] ent [NUM_ENTRIES];
    logic [WIDTH-1:0] x1_cap;
    logic [WIDTH-1:0] x2_cap;
    logic [2:0]       err_r;
    logic             piv_r;

    assign in_ready = (state == ST_LOAD);
    assign status   = {err_r, piv_r};

    assign A00 = ent[IDX_A00];
    assign A01 = ent[IDX_A01];
    assign A02 = ent[IDX_A02];
    assign A10 = ent[IDX_A10];
    assign A11 = ent[IDX_A11];
    assign A12 = ent[IDX_A12];
    assign A20 = ent[IDX_A20];
    assign A21 = ent[IDX_A21];
    assign A22 = ent[IDX_A22];
    assign C0  = ent[IDX_C0];
    assign C1  = ent[IDX_C1];
    assign C2  = ent[IDX_C2];

`ifdef LU_LOADER_PIVOT_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            piv_r <= 1'b0;
        end else if (state == ST_LOAD && in_valid) begin
            if (k == IDX_A00)
                piv_r <= 1'b0;
            else if (k == IDX_C2 && ent[IDX_A00] == '0)
                piv_r <= 1'b1;
        end
    end
`else
    assign piv_r = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LOAD;
            k         <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++)
                ent[i] <= '0;
            x1_cap    <= '0;
            x2_cap    <= '0;
            err_r     <= '0;
            solver_en <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        ent[k] <= in_data;
                        if (k == IDX_A00)
                            err_r <= '0;
                        if (k == IDX_C2) begin
                            k <= '0;
`ifdef LU_LOADER_PIVOT_CHECK_EN
                            // Zero pivot: bypass the solver and report X = 0
                            if (ent[IDX_A00] == '0) begin
                                x1_cap    <= '0;
                                x2_cap    <= '0;
                                out_valid <= 1'b1;
                                out_data  <= '0;
                                out_idx   <= 2'd0;
                                state     <= ST_OUT;
                            end else begin
                                solver_en <= 1'b1;
                                state     <= ST_SOLVE;
                            end
`else
                            solver_en <= 1'b1;
                            state     <= ST_SOLVE;
`endif
                        end else begin
                            k <= k + 4'd1;
                        end
                    end
                end
                ST_SOLVE: begin
                    if (solver_done) begin
                        x1_cap    <= X1;
                        x2_cap    <= X2;
                        err_r     <= {solver_error_fsm, solver_error_dbz, solver_error_ovf};
                        solver_en <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= X0;
                        out_idx   <= 2'd0;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (out_idx == 2'd2) begin
                            out_valid <= 1'b0;
                            state     <= ST_DRAIN;
                        end else begin
                            out_idx  <= out_idx + 2'd1;
                            out_data <= (out_idx == 2'd0) ? x1_cap : x2_cap;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!solver_done)
                        state <= ST_LOAD;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lu_matrix_loader.sv
// Scoreboard bench for lu_matrix_loader with a behavioural solver and random loads.
module tb_lu_matrix_loader;

    typedef logic [11:0][15:0] mat_t;
    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  idx;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] A00, A01, A02, A10, A11, A12, A20, A21, A22, C0, C1, C2;
    logic        solver_en;
    logic        solver_done;
    logic        solver_error_ovf, solver_error_dbz, solver_error_fsm;
    logic [15:0] X0, X1, X2;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        out_ready;
    logic [3:0]  status;
    mat_t        dut_mat;

    out_t       out_q[$];
    mat_t       mat_q[$];
    logic [3:0] stat_q[$];

    int checks = 0, failures = 0, tx_count = 0, exp_tx = 0;
    bit ident = 0;
    int err_mode = 0;
    int rdy_mode = 0;
    int stall = 0;

    always #5 clk = ~clk;

    assign dut_mat = {C2, C1, C0, A22, A21, A20, A12, A11, A10, A02, A01, A00};

    lu_matrix_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .A00(A00), .A01(A01), .A02(A02), .A10(A10), .A11(A11), .A12(A12),
        .A20(A20), .A21(A21), .A22(A22), .C0(C0), .C1(C1), .C2(C2),
        .solver_en(solver_en), .solver_done(solver_done),
        .solver_error_ovf(solver_error_ovf), .solver_error_dbz(solver_error_dbz),
        .solver_error_fsm(solver_error_fsm),
        .X0(X0), .X1(X1), .X2(X2),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_ready(out_ready), .status(status)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < 12; i++)
            m[i] = 16'($urandom);
        if (m[0] == 16'h0000)
            m[0] = 16'h0001;
        return m;
    endfunction

    // Drives n_ent entries; mode 0 = always valid, 1 = toggling, 2 = random gaps
    task automatic load(input mat_t e, input int mode, input int n_ent);
        int n = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit acc;
        bit stat_chk = 1'b0;
        bit piv = 1'b0;
`ifdef LU_LOADER_PIVOT_CHECK_EN
        piv = (e[0] == 16'h0000);
`endif
        while (n < n_ent && cyc < 2000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ph;
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_data = in_valid ? e[n] : 16'($urandom);
            @(negedge clk);
            if (stat_chk) begin
                chk("status_clear", 32'(status), 32'd0);
                stat_chk = 1'b0;
            end
            acc = in_valid && in_ready;
            if (acc && n == 11) begin
                if (piv) begin
                    for (int i = 0; i < 3; i++)
                        out_q.push_back({16'h0000, 2'(i)});
                    stat_q.push_back(4'b0001);
                end else begin
                    mat_q.push_back(e);
                end
                exp_tx++;
                chk("solver_en_early", 32'(solver_en), 32'd0);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                n++;
                if (n == 1)
                    stat_chk = 1'b1;
            end
            ph = ~ph;
            cyc++;
        end
        in_valid = 1'b0;
        if (n < n_ent)
            chk("load_timeout", 32'(n), 32'(n_ent));
        @(negedge clk);
        if (stat_chk)
            chk("status_clear", 32'(status), 32'd0);
        if (n == 12) begin
            if (piv) begin
                chk("pivot_out_valid", 32'(out_valid), 32'd1);
                chk("pivot_no_solver_en", 32'(solver_en), 32'd0);
            end else begin
                chk("solver_en_latency", 32'(solver_en), 32'd1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx(input int target);
        int cyc = 0;
        while (tx_count < target && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (tx_count < target)
            chk("tx_timeout", 32'(tx_count), 32'(target));
    endtask

    // Behavioural solver: random latency, result pushed to the scoreboard when done rises
    initial begin
        int d, hold;
        logic [2:0] e3;
        solver_done = 1'b0;
        {solver_error_fsm, solver_error_dbz, solver_error_ovf} = 3'b000;
        X0 = '0; X1 = '0; X2 = '0;
        forever begin
            @(negedge clk);
            if (rst && solver_en) begin
                d = ident ? 50 : $urandom_range(1, 20);
                for (int i = 1; i < d; i++) begin
                    @(negedge clk);
                    chk("solver_en_hold", 32'(solver_en), 32'd1);
                end
                if (ident) begin
                    X0 = 16'h0020; X1 = 16'h0030; X2 = 16'h0040;
                end else begin
                    X0 = 16'($urandom); X1 = 16'($urandom); X2 = 16'($urandom);
                end
                case (err_mode)
                    0:       e3 = 3'b000;
                    2:       e3 = 3'b010;
                    default: e3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                endcase
                {solver_error_fsm, solver_error_dbz, solver_error_ovf} = e3;
                solver_done = 1'b1;
                out_q.push_back({X0, 2'd0});
                out_q.push_back({X1, 2'd1});
                out_q.push_back({X2, 2'd2});
                stat_q.push_back({e3, 1'b0});
                @(negedge clk);
                chk("done_to_out_valid", 32'(out_valid), 32'd1);
                chk("solver_en_drop", 32'(solver_en), 32'd0);
                hold = ident ? 0 : $urandom_range(0, 6);
                repeat (hold) begin
                    chk("in_ready_drain", 32'(in_ready), 32'd0);
                    @(negedge clk);
                end
                solver_done = 1'b0;
                {solver_error_fsm, solver_error_dbz, solver_error_ovf} = 3'b000;
            end
        end
    end

    // Downstream ready: 0 = always, 1 = random, 2 = stall 5 cycles on idx 1
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && out_idx == 2'd1 && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: matrix at solver_en rise, outputs on each transfer, stability under stall
    initial begin
        bit en_q = 1'b0;
        bit hold_q = 1'b0;
        logic [15:0] hd = '0;
        logic [1:0] hi = '0;
        mat_t m;
        out_t o;
        forever begin
            @(negedge clk);
            if (!rst) begin
                en_q = 1'b0;
                hold_q = 1'b0;
            end else begin
                if (solver_en && !en_q) begin
                    if (mat_q.size() == 0) begin
                        chk("solver_en_unexpected", 32'd1, 32'd0);
                    end else begin
                        m = mat_q.pop_front();
                        for (int i = 0; i < 12; i++)
                            chk($sformatf("matrix_entry%0d", i), 32'(dut_mat[i]), 32'(m[i]));
                    end
                end
                if (hold_q) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(hd));
                    chk("hold_idx", 32'(out_idx), 32'(hi));
                end
                if (out_valid && out_ready) begin
                    if (out_q.size() == 0) begin
                        chk("out_unexpected", 32'd1, 32'd0);
                    end else begin
                        o = out_q.pop_front();
                        chk("out_data", 32'(out_data), 32'(o.data));
                        chk("out_idx", 32'(out_idx), 32'(o.idx));
                        if (o.idx == 2'd0) begin
                            if (stat_q.size() == 0)
                                chk("status_unexpected", 32'd1, 32'd0);
                            else
                                chk("status", 32'(status), 32'(stat_q.pop_front()));
                        end
                        if (o.idx == 2'd2)
                            tx_count++;
                    end
                end
                hold_q = out_valid && !out_ready;
                hd = out_data;
                hi = out_idx;
                en_q = solver_en;
            end
        end
    end

    initial begin
        mat_t m;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_matrix_zero", 32'(|dut_mat), 32'd0);
        chk("reset_solver_en", 32'(solver_en), 32'd0);
        chk("reset_out", {13'd0, out_valid, out_idx, out_data}, 32'd0);
        chk("reset_status", 32'(status), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Identity system, solver returns C after 50 cycles
        ident = 1'b1;
        m = '0;
        m[0] = 16'h0010; m[4] = 16'h0010; m[8] = 16'h0010;
        m[9] = 16'h0020; m[10] = 16'h0030; m[11] = 16'h0040;
        load(m, 0, 12);
        wait_tx(exp_tx);
        ident = 1'b0;

        // Toggling in_valid, downstream stall on idx 1
        rdy_mode = 2;
        stall = 0;
        load(rand_mat(), 1, 12);
        wait_tx(exp_tx);
        rdy_mode = 0;

        // Divide-by-zero reported by the solver; next load clears status
        err_mode = 2;
        load(rand_mat(), 0, 12);
        wait_tx(exp_tx);
        err_mode = 0;

        // Reset after 7 entries, then a fresh full load
        m = rand_mat();
        load(m, 0, 7);
        chk("partial_a00", 32'(A00), 32'(m[0]));
        rst = 1'b0;
        #1;
        chk("midload_rst_matrix", 32'(|dut_mat), 32'd0);
        chk("midload_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midload_rst_out", {12'd0, solver_en, out_valid, out_idx, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        load(rand_mat(), 2, 12);
        wait_tx(exp_tx);

        // Zero pivot in A00
        m = rand_mat();
        m[0] = 16'h0000;
        load(m, 0, 12);
        wait_tx(exp_tx);

        // Back-to-back random loads with random backpressure and errors
        rdy_mode = 1;
        err_mode = 1;
        for (int t = 0; t < 8; t++)
            load(rand_mat(), 2, 12);
        wait_tx(exp_tx);

        chk("out_q_empty", 32'(out_q.size()), 32'd0);
        chk("mat_q_empty", 32'(mat_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lu_matrix_loader.md
LU_MATRIX_LOADER -- requirements
Module: lu_matrix_loader

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; one clock, reset asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, upstream entry valid.
REQ-004 SHALL have port in_data, input, 16, signed Q12.4 entry.
REQ-005 SHALL have port in_ready, output, 1, loader accepts an entry.
REQ-006 SHALL have ports A00..A22 and C0..C2, output, 16 each, registered matrix/vector to the solver.
REQ-007 SHALL have port solver_en, output, 1, solver enable.
REQ-008 SHALL have ports solver_done, solver_error_ovf, solver_error_dbz and solver_error_fsm, input, 1 each.
REQ-009 SHALL have ports X0, X1 and X2, input, 16 each, solver results.
REQ-010 SHALL have port out_valid, output, 1; port out_data, output, 16; port out_idx, output, 2; port out_ready, input, 1.
REQ-011 SHALL have port status, output, 4: {fsm, dbz, ovf, pivot} error flags of the last solve.

Function
REQ-012 SHALL implement states LOAD, SOLVE, OUT and DRAIN.
REQ-013 LOAD: in_ready=1; each cycle with in_valid&in_ready stores in_data into entry counter k (0..11); order A00,A01,A02,A10,A11,A12,A20,A21,A22,C0,C1,C2.
REQ-014 LOAD: accepting entry k=11 SHALL go to SOLVE next cycle, clear k and drive solver_en=1 from that cycle.
REQ-015 SOLVE: solver_en SHALL hold 1 and A*/C* SHALL hold stable until solver_done=1.
REQ-016 SOLVE: in the cycle solver_done=1, SHALL capture X0..X2 and the three solver error flags into status, then go to OUT.
REQ-017 OUT: solver_en=0; out_valid=1; out_data is X0, X1, X2 in order with out_idx 0,1,2; each advances only on out_valid&out_ready.
REQ-018 OUT: out_data/out_idx SHALL stay stable while out_valid&!out_ready.
REQ-019 OUT: the transfer with out_idx=2 SHALL go to DRAIN.
REQ-020 DRAIN: SHALL wait until solver_done=0, then go to LOAD; in_ready=0 outside LOAD.
REQ-021 Latency: first accepted entry to solver_en=1 is at least 12 cycles; solver_done=1 to first out_valid is 1 cycle.
REQ-022 Entries SHALL be stored unmodified (no saturation or conversion).
REQ-023 in_valid outside LOAD SHALL be ignored; pending entries are not lost because in_ready=0.
REQ-024 status SHALL clear on the first accepted entry of a new load.
REQ-025 Back-to-back out_ready=1 SHALL yield 3 consecutive output cycles.
REQ-026 solver_done=1 seen in LOAD SHALL be ignored.

Reset
REQ-027 rst=0 SHALL force state LOAD and k=0.
REQ-028 rst=0 SHALL force A*, C*, captured X, status, solver_en, out_valid, out_data and out_idx to 0.
REQ-029 in_ready SHALL be 1 during and immediately after reset.
REQ-030 Reset mid-load or mid-solve SHALL discard all partial data; the next load restarts at A00.

Configuration
REQ-031 With LU_LOADER_PIVOT_CHECK_EN defined, accepting entry k=11 while stored A00==0 SHALL set status[0], skip SOLVE, and go to OUT emitting X0..X2 as 0.
REQ-032 Without LU_LOADER_PIVOT_CHECK_EN, status[0] SHALL be constant 0 and there is no pivot check.

Structure
REQ-033 Shared package lu_pkg SHALL hold WIDTH=16, FBITS=4, NUM_ENTRIES=12, the state enum and the entry-index constants.
REQ-034 No sub-module; single flat module.

Verification
REQ-035 Identity load A=diag(0x0010), C=(0x0020,0x0030,0x0040), solver model returns X=C after 50 cycles with done held until en=0 -> solver_en high exactly until done; outputs 0x0020/0,0x0030/1,0x0040/2; status=0.
REQ-036 in_valid toggling 1/0 every cycle during load -> all 12 entries land in correct registers; solver_en asserts 1 cycle after 12th handshake.
REQ-037 out_ready low 5 cycles on idx 1 -> out_data/out_idx stable, no skipped or duplicated index.
REQ-038 Solver model asserts error_dbz with done -> status=4'b0100; next load's first entry clears status.
REQ-039 Reset asserted after entry 7 -> all outputs 0, in_ready=1; a fresh 12-entry load completes normally.
REQ-040 Macro defined, A00=0x0000 -> solver_en never asserts, status[0]=1, three outputs of 0x0000.
